netwalk_tcam_match_resolver: RTL and testbench
==============================================

Name:
netwalk_tcam_match_resolver

Overview:
- Sits directly downstream of the TCAM unit array.
- Collects the one-bit match outputs of all NUM_ENTRIES TCAM units into a vector and resolves them to a single matched address.
- Lowest index has highest priority.
- Two-stage pipeline with valid/ready handshakes on both sides; feeds the flow-table action lookup. Also keeps hit and miss statistics counters.

Parameters:
- NUM_ENTRIES, 256: number of TCAM units (width of the match vector); must equal 2**TCAM_ADDR_WIDTH.
- TCAM_ADDR_WIDTH, 8: width of the resolved address.
- GROUP_WIDTH, 16: stage-1 group size; power of two; NUM_ENTRIES must be a multiple of it.
- CNT_WIDTH, 32: width of the hit and miss statistics counters.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low; the block is in reset while reset=0.
- match_vec, in, NUM_ENTRIES: bit i is the of_matched_addr_out of TCAM unit i.
- match_vec_valid, in, 1: match_vec holds a valid lookup result.
- match_vec_ready, out, 1: the block accepts match_vec this cycle.
- of_matched_addr, out, TCAM_ADDR_WIDTH: resolved (lowest-index) matching entry.
- of_match_hit, out, 1: at least one entry matched.
- of_match_valid, out, 1: the output fields are valid.
- of_match_ready, in, 1: the downstream stage accepts the output.
- count_clear, in, 1: synchronous clear of both counters.
- hit_count, out, CNT_WIDTH: number of delivered results with hit=1.
- miss_count, out, CNT_WIDTH: number of delivered results with hit=0.

Behaviour:
- Reset (asynchronous, reset=0):
  - s1_valid=0 and s2_valid=0, so of_match_valid=0.
  - of_matched_addr=0, of_match_hit=0, hit_count=0, miss_count=0.
  - Any lookup in flight is discarded; nothing is emitted after reset releases.
- Input handshake: a transfer occurs when match_vec_valid & match_vec_ready.
  - match_vec_ready = !s1_valid | s1_adv.
- Stage 1, on accept: for each group g (GROUP_WIDTH bits), register:
  - grp_hit[g] = OR of the group's bits;
  - grp_idx[g] = index of the lowest set bit within the group (log2(GROUP_WIDTH) bits; 0 if the group is empty).
- Stage 2 advance: s2_adv = s1_valid & (!s2_valid | of_match_ready).
- Stage 2 result:
  - Select the lowest g with grp_hit[g]=1; of_matched_addr = {g, grp_idx[g]}; of_match_hit=1.
  - If no group hit: of_matched_addr=0, of_match_hit=0.
- Stage 1 advance: s1_adv = s2_adv. Stage 1 reloads from the input when it accepts; otherwise s1_valid clears when it advances.
- Output registers are the stage-2 registers.
  - While of_match_valid & !of_match_ready, all outputs hold stable.
  - of_match_valid deasserts only after a handshake with no new data behind it.
- Latency and throughput:
  - With of_match_ready=1, the result appears 2 cycles after the input handshake.
  - Throughput is 1 lookup per cycle.
  - Under backpressure, at most 2 lookups are buffered; results keep input order; none are dropped or duplicated.
- Counters:
  - On each output handshake, increment hit_count if of_match_hit=1, otherwise miss_count.
  - Both counters saturate at all-ones and do not wrap.
  - count_clear=1 zeroes both counters and takes priority over a same-cycle increment; that event is not counted.
- match_vec_valid=0 with match_vec toggling: no state change.
- match_vec is sampled only on a handshake.

Decomposition:
- Shared package netwalk_tcam_pkg:
  - constants for TCAM_ADDR_WIDTH, NUM_ENTRIES and GROUP_WIDTH;
  - a derived GRP_IDX_WIDTH = log2(GROUP_WIDTH);
  - NUM_GROUPS = NUM_ENTRIES / GROUP_WIDTH.
- Sub-module netwalk_prio_enc:
  - parameterised combinational lowest-index priority encoder (WIDTH in; outputs any and idx);
  - instantiated NUM_GROUPS times in stage 1 and once (WIDTH=NUM_GROUPS) in stage 2.

Test Plan:
- Bits 37 and 200 set, valid for 1 cycle, ready=1 -> 2 cycles later valid=1, addr=37, hit=1; hit_count=1.
- All-zero vector -> addr=0, hit=0 after 2 cycles; miss_count=1, hit_count unchanged.
- Boundaries: only bit 255 set -> addr=255; only bit 16 set -> addr=16; only bit 15 set -> addr=15; all bits set -> addr=0.
- Backpressure:
  - Stimulus: stream vectors with bits 1, 2, 3, 4 back-to-back while of_match_ready=0 for 4 cycles.
  - Response: match_vec_ready drops after 2 accepts; addr=1 holds stable; after ready=1 the outputs are 1, 2, 3, 4 in order with no gaps or duplicates.
- Reset mid-flight: assert reset=0 asynchronously with both stages valid -> of_match_valid=0 immediately, counters=0; no stale output after release.
- Counter saturation (CNT_WIDTH=4) and clear:
  - 17 hits -> hit_count=15.
  - count_clear in the same cycle as a hit handshake -> hit_count=0.

Source files
------------

// File: rtl/netwalk_tcam_pkg.sv
// netwalk_tcam_pkg
// Shared constants for the TCAM match path. It also holds a small helper that
// sizes index fields so that a one-bit vector still gets a one-bit index.
package netwalk_tcam_pkg;

  localparam int TCAM_ADDR_WIDTH = 8;
  localparam int NUM_ENTRIES     = 2 ** TCAM_ADDR_WIDTH;
  localparam int GROUP_WIDTH     = 16;
  localparam int GRP_IDX_WIDTH   = $clog2(GROUP_WIDTH);
  localparam int NUM_GROUPS      = NUM_ENTRIES / GROUP_WIDTH;

  // Width of an index into a vector of w bits (never zero).
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/netwalk_prio_enc.sv
// netwalk_prio_enc
// Combinational lowest-index priority encoder.
//   vec : input vector, bit 0 has the highest priority
//   any : at least one bit of vec is set
//   idx : index of the lowest set bit (0 when vec is all zero)
module netwalk_prio_enc
  import netwalk_tcam_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so that the last hit written is the lowest index.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/netwalk_tcam_match_resolver.sv
// netwalk_tcam_match_resolver
// Resolves the per-entry TCAM match bits into the lowest matching address
// through a two-stage pipeline, and counts delivered hits and misses.
//   clk, reset         : clock (rising edge), asynchronous active-low reset
//   match_vec          : one match bit per TCAM entry
//   match_vec_valid/_ready : input handshake
//   of_matched_addr    : lowest matching entry (0 on miss)
//   of_match_hit       : at least one entry matched
//   of_match_valid/_ready  : output handshake
//   count_clear        : synchronous clear of both counters (wins over increment)
//   hit_count/miss_count : saturating counts of delivered results
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until the transfer; this block never changes its outputs while
// of_match_valid is high and of_match_ready is low.
module netwalk_tcam_match_resolver #(
  parameter int NUM_ENTRIES     = netwalk_tcam_pkg::NUM_ENTRIES,
  parameter int TCAM_ADDR_WIDTH = netwalk_tcam_pkg::TCAM_ADDR_WIDTH,
  parameter int GROUP_WIDTH     = netwalk_tcam_pkg::GROUP_WIDTH,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_ENTRIES-1:0]     match_vec,
  input  logic                       match_vec_valid,
  output logic                       match_vec_ready,
  output logic [TCAM_ADDR_WIDTH-1:0] of_matched_addr,
  output logic                       of_match_hit,
  output logic                       of_match_valid,
  input  logic                       of_match_ready,
  input  logic                       count_clear,
  output logic [CNT_WIDTH-1:0]       hit_count,
  output logic [CNT_WIDTH-1:0]       miss_count
);

  localparam int NUM_GROUPS = NUM_ENTRIES / GROUP_WIDTH;
  localparam int GRP_IDX_W  = netwalk_tcam_pkg::idx_width(GROUP_WIDTH);
  localparam int GRP_SEL_W  = netwalk_tcam_pkg::idx_width(NUM_GROUPS);

  // Pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic in_fire;
  logic out_fire;

  assign s2_adv          = s1_valid & (~s2_valid | of_match_ready);
  assign s1_adv          = s2_adv;
  assign match_vec_ready = ~s1_valid | s1_adv;
  assign in_fire         = match_vec_valid & match_vec_ready;
  assign out_fire        = s2_valid & of_match_ready;
  assign of_match_valid  = s2_valid;

  // Stage 1: per-group encoders
  logic [NUM_GROUPS-1:0] grp_hit_d;
  logic [GRP_IDX_W-1:0]  grp_idx_d [NUM_GROUPS];
  logic [NUM_GROUPS-1:0] grp_hit_q;
  logic [GRP_IDX_W-1:0]  grp_idx_q [NUM_GROUPS];

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    netwalk_prio_enc #(
      .WIDTH (GROUP_WIDTH),
      .IDX_W (GRP_IDX_W)
    ) u_grp_enc (
      .vec (match_vec[g*GROUP_WIDTH +: GROUP_WIDTH]),
      .any (grp_hit_d[g]),
      .idx (grp_idx_d[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      grp_hit_q <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) grp_idx_q[g] <= '0;
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      grp_hit_q <= grp_hit_d;
      for (int g = 0; g < NUM_GROUPS; g++) grp_idx_q[g] <= grp_idx_d[g];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: pick the lowest hitting group, then its in-group index
  logic                       grp_any;
  logic [GRP_SEL_W-1:0]       grp_sel;
  logic [TCAM_ADDR_WIDTH-1:0] addr_d;

  netwalk_prio_enc #(
    .WIDTH (NUM_GROUPS),
    .IDX_W (GRP_SEL_W)
  ) u_sel_enc (
    .vec (grp_hit_q),
    .any (grp_any),
    .idx (grp_sel)
  );

  always_comb begin
    addr_d = '0;
    if (grp_any) addr_d = TCAM_ADDR_WIDTH'({grp_sel, grp_idx_q[grp_sel]});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid        <= 1'b0;
      of_matched_addr <= '0;
      of_match_hit    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid        <= 1'b1;
      of_matched_addr <= addr_d;
      of_match_hit    <= grp_any;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Statistics: saturating, clear has priority over a same-cycle delivery
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (count_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (out_fire) begin
      if (of_match_hit) begin
        if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_netwalk_tcam_match_resolver.sv
// tb_netwalk_tcam_match_resolver
// Directed and short randomised stimulus against a queue-based model of the
// resolver: each accepted vector is turned into its expected {hit, addr} from
// a plain lowest-set-bit search, and results must emerge in order.
module tb_netwalk_tcam_match_resolver;

  localparam int N   = 256;
  localparam int AW  = 8;
  localparam int CW  = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  match_vec;
  logic          match_vec_valid;
  logic          match_vec_ready;
  logic [AW-1:0] of_matched_addr;
  logic          of_match_hit;
  logic          of_match_valid;
  logic          of_match_ready;
  logic          count_clear;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  always #5 clk = ~clk;

  netwalk_tcam_match_resolver #(
    .NUM_ENTRIES     (N),
    .TCAM_ADDR_WIDTH (AW),
    .GROUP_WIDTH     (16),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .match_vec       (match_vec),
    .match_vec_valid (match_vec_valid),
    .match_vec_ready (match_vec_ready),
    .of_matched_addr (of_matched_addr),
    .of_match_hit    (of_match_hit),
    .of_match_valid  (of_match_valid),
    .of_match_ready  (of_match_ready),
    .count_clear     (count_clear),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // {hit, addr}: the lowest set bit wins; an empty vector is a miss at 0.
  function automatic logic [8:0] model(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return {1'b1, 8'(i)};
    return 9'h000;
  endfunction

  function automatic logic [N-1:0] onehot(input int b);
    logic [N-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] gen_vec();
    logic [N-1:0] v;
    int mode;
    v = '0;
    mode = $urandom_range(0, 3);
    case (mode)
      0: v = '0;
      1: v[$urandom_range(0, N-1)] = 1'b1;
      2: begin
        v[$urandom_range(0, N-1)] = 1'b1;
        v[$urandom_range(0, N-1)] = 1'b1;
      end
      default: for (int w = 0; w < N/32; w++) v[w*32 +: 32] = $urandom & $urandom;
    endcase
    return v;
  endfunction

  logic [8:0]    exp_q[$];
  logic [CW-1:0] m_hits;
  logic [CW-1:0] m_miss;
  logic          hold_prev;
  logic [AW-1:0] hold_addr;
  logic          hold_hit;
  logic [8:0]    head;

  // Model update on each clock edge from the handshakes seen at that edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_hits    = '0;
      m_miss    = '0;
      hold_prev = 1'b0;
      hold_addr = '0;
      hold_hit  = 1'b0;
    end else begin
      hold_prev = of_match_valid && !of_match_ready;
      hold_addr = of_matched_addr;
      hold_hit  = of_match_hit;
      head      = 9'h000;
      if (of_match_valid && of_match_ready && exp_q.size() > 0) head = exp_q.pop_front();
      if (count_clear) begin
        m_hits = '0;
        m_miss = '0;
      end else if (of_match_valid && of_match_ready) begin
        if (head[8]) begin
          if (m_hits != '1) m_hits = m_hits + 1'b1;
        end else begin
          if (m_miss != '1) m_miss = m_miss + 1'b1;
        end
      end
      if (match_vec_valid && match_vec_ready) exp_q.push_back(model(match_vec));
    end
  end

  // ---------------- scoreboard compare (every falling edge) ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_valid", 32'(of_match_valid), 0);
      chk("rst_hit_count", 32'(hit_count), 0);
      chk("rst_miss_count", 32'(miss_count), 0);
    end else begin
      chk("hit_count", 32'(hit_count), 32'(m_hits));
      chk("miss_count", 32'(miss_count), 32'(m_miss));
      chk("inflight_le2", 32'(exp_q.size() <= 2), 1);
      if (hold_prev) begin
        chk("hold_valid", 32'(of_match_valid), 1);
        chk("hold_addr", 32'(of_matched_addr), 32'(hold_addr));
        chk("hold_hit", 32'(of_match_hit), 32'(hold_hit));
      end
      if (of_match_valid) begin
        chk("valid_has_expect", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("sb_addr", 32'(of_matched_addr), 32'(exp_q[0][7:0]));
          chk("sb_hit", 32'(of_match_hit), 32'(exp_q[0][8]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single lookup into an idle pipeline with of_match_ready=1.
  task automatic lookup(input logic [N-1:0] v, input int ea, input int eh,
                        input int ehc, input int emc, input string nm);
    match_vec       = v;
    match_vec_valid = 1'b1;
    step();
    match_vec_valid = 1'b0;
    match_vec       = '0;
    @(negedge clk);
    chk({nm, "_not_yet"}, 32'(of_match_valid), 0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(of_match_valid), 1);
    chk({nm, "_addr"}, 32'(of_matched_addr), ea);
    chk({nm, "_hit"}, 32'(of_match_hit), eh);
    step();
    @(negedge clk);
    chk({nm, "_done"}, 32'(of_match_valid), 0);
    chk({nm, "_hits"}, 32'(hit_count), ehc);
    chk({nm, "_misses"}, 32'(miss_count), emc);
    step();
  endtask

  // ---------------- main sequence ----------------
  logic [N-1:0] v;
  int           sent;
  logic         acc;

  initial begin
    reset           = 1'b0;
    match_vec       = '0;
    match_vec_valid = 1'b0;
    of_match_ready  = 1'b1;
    count_clear     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", 32'(of_matched_addr), 0);
    chk("reset_hit", 32'(of_match_hit), 0);
    step();
    reset = 1'b1;
    step();

    // Basic lookups and address boundaries
    v = '0; v[37] = 1'b1; v[200] = 1'b1;
    lookup(v, 37, 1, 1, 0, "bits_37_200");
    lookup('0, 0, 0, 1, 1, "all_zero");
    lookup(onehot(255), 255, 1, 2, 1, "bit_255");
    lookup(onehot(16), 16, 1, 3, 1, "bit_16");
    lookup(onehot(15), 15, 1, 4, 1, "bit_15");
    lookup('1, 0, 1, 5, 1, "all_ones");

    // Backpressure: ready low for 4 cycles while streaming bits 1..4
    of_match_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 4) of_match_ready = 1'b1;
      if (sent < 4) begin
        match_vec       = onehot(sent + 1);
        match_vec_valid = 1'b1;
      end else begin
        match_vec       = '0;
        match_vec_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        chk("bp_in_ready_low", 32'(match_vec_ready), 0);
        chk("bp_hold_valid", 32'(of_match_valid), 1);
        chk("bp_hold_addr1", 32'(of_matched_addr), 1);
      end
      if (cyc >= 4) begin
        chk("bp_out_valid", 32'(of_match_valid), 1);
        chk("bp_out_addr", 32'(of_matched_addr), cyc - 3);
      end
      acc = match_vec_valid && match_vec_ready;
      step();
      if (acc) sent++;
    end
    @(negedge clk);
    chk("bp_all_sent", sent, 4);
    chk("bp_drained", 32'(of_match_valid), 0);
    chk("bp_hits", 32'(hit_count), 9);
    step();

    // Reset with both stages full
    of_match_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      match_vec       = onehot(9 + k);
      match_vec_valid = 1'b1;
      step();
    end
    match_vec_valid = 1'b0;
    @(negedge clk);
    chk("mid_full_valid", 32'(of_match_valid), 1);
    chk("mid_in_ready", 32'(match_vec_ready), 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(of_match_valid), 0);
    chk("mid_rst_addr", 32'(of_matched_addr), 0);
    chk("mid_rst_hits", 32'(hit_count), 0);
    chk("mid_rst_misses", 32'(miss_count), 0);
    step();
    reset          = 1'b1;
    of_match_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale_out", 32'(of_match_valid), 0);
      step();
    end

    // Saturation: 17 hits into a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      match_vec       = onehot($urandom_range(0, N-1));
      match_vec_valid = 1'b1;
      step();
    end
    match_vec_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("sat_hits", 32'(hit_count), 15);
    chk("sat_misses", 32'(miss_count), 0);
    step();

    // Clear in the same cycle as a hit handshake
    match_vec       = onehot(7);
    match_vec_valid = 1'b1;
    step();
    match_vec_valid = 1'b0;
    step();
    count_clear = 1'b1;
    @(negedge clk);
    chk("clr_pending_valid", 32'(of_match_valid), 1);
    step();
    count_clear = 1'b0;
    @(negedge clk);
    chk("clr_beats_hit", 32'(hit_count), 0);
    step();

    // Idle input toggling has no effect
    for (int k = 0; k < 5; k++) begin
      match_vec       = gen_vec();
      match_vec_valid = 1'b0;
      step();
      @(negedge clk);
      chk("idle_no_out", 32'(of_match_valid), 0);
      chk("idle_hits", 32'(hit_count), 0);
    end
    step();

    // Randomised traffic with random backpressure and occasional clears
    for (int k = 0; k < 60; k++) begin
      match_vec_valid = 1'($urandom_range(0, 1));
      match_vec       = gen_vec();
      of_match_ready  = ($urandom_range(0, 3) != 0);
      count_clear     = ($urandom_range(0, 15) == 0);
      step();
    end
    match_vec_valid = 1'b0;
    of_match_ready  = 1'b1;
    count_clear     = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 0);
    chk("drain_valid_low", 32'(of_match_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
